// File: rtl/sm_accumulator.sv
// Sign-magnitude product accumulator: sums sign-magnitude terms in two's complement and emits
// a sign-magnitude result per dot product. Define SM_ACC_SATURATE_EN to clamp instead of wrap on overflow.
module sm_accumulator #(
    parameter int demention_prod = 8,
    parameter int demention_acc  = 12,
    parameter int demention_cnt  = 8
) (
    input  logic                     iClk,
    input  logic                     iRst_n,
    input  logic                     iValid,
    output logic                     oReady,
    input  logic [demention_prod-1:0] iProduct,
    input  logic                     iLast,
    output logic                     oValid,
    input  logic                     iReady,
    output logic [demention_acc-1:0] oSum,
    output logic [demention_cnt-1:0] oCount,
    output logic                     oOverflow,
    output logic                     oDbgState
);

    localparam int MW  = demention_prod - 1;
    localparam int PAD = demention_acc - MW;

    localparam logic [demention_acc-1:0] ACC_ONE  = {{(demention_acc-1){1'b0}}, 1'b1};
    localparam logic [demention_acc-1:0] ACC_MAX  = {1'b0, {(demention_acc-1){1'b1}}};
    localparam logic [demention_acc-1:0] ACC_MIN  = {1'b1, {(demention_acc-1){1'b0}}};
    localparam logic [demention_acc-1:0] ACC_NMAX = {1'b1, {(demention_acc-2){1'b0}}, 1'b1};
    localparam logic [demention_acc-2:0] MAG_MAX  = {(demention_acc-1){1'b1}};
    localparam logic [demention_cnt-1:0] CNT_ONE  = {{(demention_cnt-1){1'b0}}, 1'b1};

    // Handshake: a product is taken on a rising edge when iValid && oReady; a result is
    // released on a rising edge when oValid && iReady. Neither side may retract data while waiting.
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t state, next_state;
    logic   accept;
    logic   release_res;

    logic [demention_acc-1:0] acc;
    logic [demention_cnt-1:0] cnt;
    logic                     ovf_flag;

    logic [demention_acc-1:0] prod_ext;
    logic [demention_acc-1:0] prod_conv;
    logic [demention_acc:0]   sum_ext;
    logic                     add_ovf;
    logic [demention_acc-1:0] acc_sum;
    logic [demention_cnt-1:0] cnt_next;
    logic                     ovf_next;
    logic [demention_acc-1:0] neg_mag;
    logic [demention_acc-1:0] sm_result;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state <= ACCUM;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        oReady      = 1'b0;
        oValid      = 1'b0;
        accept      = 1'b0;
        release_res = 1'b0;
        case (state)
            ACCUM: begin
                oReady = 1'b1;
                accept = iValid;
                if (iValid && iLast) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                oValid      = 1'b1;
                release_res = iReady;
                if (iReady) begin
                    next_state = ACCUM;
                end
            end
            default: next_state = ACCUM;
        endcase
    end

    assign oDbgState = state;

    // Negative zero negates to zero, so it contributes nothing.
    assign prod_ext  = {{PAD{1'b0}}, iProduct[MW-1:0]};
    assign prod_conv = iProduct[demention_prod-1] ? (~prod_ext + ACC_ONE) : prod_ext;

    // One extra bit holds the true sign; a disagreement with the wrapped MSB is an overflow.
    assign sum_ext = {acc[demention_acc-1], acc} + {prod_conv[demention_acc-1], prod_conv};
    assign add_ovf = sum_ext[demention_acc] ^ sum_ext[demention_acc-1];

    always_comb begin
        acc_sum = sum_ext[demention_acc-1:0];
`ifdef SM_ACC_SATURATE_EN
        if (add_ovf) begin
            acc_sum = sum_ext[demention_acc] ? ACC_NMAX : ACC_MAX;
        end
`endif
    end

    assign cnt_next = (&cnt) ? cnt : (cnt + CNT_ONE);
    assign ovf_next = ovf_flag | add_ovf;

    // The most negative value has no positive twin in demention_acc-1 bits, so it clamps.
    assign neg_mag = ~acc_sum + ACC_ONE;

    always_comb begin
        sm_result = {1'b0, acc_sum[demention_acc-2:0]};
        if (acc_sum[demention_acc-1]) begin
            if (acc_sum == ACC_MIN) begin
                sm_result = {1'b1, MAG_MAX};
            end else begin
                sm_result = {1'b1, neg_mag[demention_acc-2:0]};
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            acc       <= '0;
            cnt       <= '0;
            ovf_flag  <= 1'b0;
            oSum      <= '0;
            oCount    <= '0;
            oOverflow <= 1'b0;
        end else if (release_res) begin
            acc      <= '0;
            cnt      <= '0;
            ovf_flag <= 1'b0;
        end else if (accept) begin
            acc      <= acc_sum;
            cnt      <= cnt_next;
            ovf_flag <= ovf_next;
            if (iLast) begin
                oSum      <= sm_result;
                oCount    <= cnt_next;
                oOverflow <= ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_sm_accumulator.sv
// Directed + random bench for sm_accumulator with a reference model feeding an expected-result queue.
module tb_sm_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  in_product;
    logic        in_last;
    logic        out_valid;
    logic        in_ready;
    logic [11:0] out_sum;
    logic [7:0]  out_count;
    logic        out_overflow;
    logic        dbg_state;

    int errors = 0;
    int checks = 0;

    logic [20:0] exp_q[$];
    int          m_acc = 0;
    int          m_cnt = 0;
    bit          m_ovf = 1'b0;

    sm_accumulator #(
        .demention_prod(8),
        .demention_acc (12),
        .demention_cnt (8)
    ) dut (
        .iClk     (clk),
        .iRst_n   (rst_n),
        .iValid   (in_valid),
        .oReady   (out_ready),
        .iProduct (in_product),
        .iLast    (in_last),
        .oValid   (out_valid),
        .iReady   (in_ready),
        .oSum     (out_sum),
        .oCount   (out_count),
        .oOverflow(out_overflow),
        .oDbgState(dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: integer sum with explicit range test, then wrap or clamp.
    task automatic model_beat(input logic [7:0] p, input logic last);
        int          v;
        int          s;
        int          mag;
        logic [11:0] sm;
        v = int'(p[6:0]);
        if (p[7]) v = -v;
        s = m_acc + v;
        if (s > 2047 || s < -2048) begin
            m_ovf = 1'b1;
`ifdef SM_ACC_SATURATE_EN
            s = (s > 0) ? 2047 : -2047;
`else
            s = (s > 0) ? s - 4096 : s + 4096;
`endif
        end
        m_acc = s;
        if (m_cnt < 255) m_cnt++;
        if (last) begin
            if (s < 0) begin
                mag = -s;
                if (mag > 2047) mag = 2047;
                sm = {1'b1, 11'(mag)};
            end else begin
                sm = {1'b0, 11'(s)};
            end
            exp_q.push_back({m_ovf, 8'(m_cnt), sm});
            m_acc = 0;
            m_cnt = 0;
            m_ovf = 1'b0;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is taken.
    task automatic send_beat(input logic [7:0] p, input logic last);
        int wait_n;
        wait_n     = 0;
        in_valid   = 1'b1;
        in_product = p;
        in_last    = last;
        while (!out_ready && wait_n < 50) begin
            @(posedge clk);
            #1;
            wait_n++;
        end
        if (!out_ready) begin
            check("accept_timeout", 32'(out_ready), 32'd1);
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        model_beat(p, last);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (last) check("latency_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic collect(input string tag);
        int          wait_n;
        logic [20:0] e;
        wait_n = 0;
        while (!out_valid && wait_n < 50) begin
            @(posedge clk);
            #1;
            wait_n++;
        end
        if (!out_valid) begin
            check({tag, "_timeout"}, 32'(out_valid), 32'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected"}, 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_sum"}, 32'(out_sum), 32'(e[11:0]));
        check({tag, "_count"}, 32'(out_count), 32'(e[19:12]));
        check({tag, "_ovf"}, 32'(out_overflow), 32'(e[20]));
        in_ready = 1'b1;
        @(posedge clk);
        #1;
        in_ready = 1'b0;
        check({tag, "_released"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_after"}, 32'(out_ready), 32'd1);
    endtask

    initial begin
        rst_n      = 1'b1;
        in_valid   = 1'b0;
        in_product = 8'h00;
        in_last    = 1'b0;
        in_ready   = 1'b0;
        #2 rst_n = 1'b0;
        #20 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(out_sum), 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        check("rst_ovf", 32'(out_overflow), 32'd0);
        check("rst_ready", 32'(out_ready), 32'd1);

        send_beat(8'h05, 1'b0);
        send_beat(8'h83, 1'b0);
        send_beat(8'h02, 1'b1);
        check("mix_literal", 32'(out_sum), 32'h004);
        collect("mix");

        send_beat(8'h85, 1'b0);
        send_beat(8'h80, 1'b0);
        send_beat(8'h81, 1'b1);
        check("neg_literal", 32'(out_sum), 32'h806);
        collect("neg");

        for (int i = 0; i < 17; i++) send_beat(8'h7F, i == 16);
`ifdef SM_ACC_SATURATE_EN
        check("ovf_literal", 32'(out_sum), 32'h7FF);
`else
        check("ovf_literal", 32'(out_sum), 32'hF91);
`endif
        collect("ovf");

        for (int i = 0; i < 16; i++) send_beat(8'hFF, 1'b0);
        send_beat(8'h90, 1'b1);
        collect("min_clamp");

        // Backpressure: result held while the downstream stalls and iValid stays high.
        send_beat(8'h01, 1'b1);
        in_valid   = 1'b1;
        in_product = 8'h7F;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_ready", 32'(out_ready), 32'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_sum", 32'(out_sum), 32'(exp_q[0][11:0]));
            check("bp_count", 32'(out_count), 32'(exp_q[0][19:12]));
        end
        in_ready = 1'b1;
        @(posedge clk);
        #1;
        in_ready = 1'b0;
        void'(exp_q.pop_front());
        check("bp_released", 32'(out_valid), 32'd0);
        check("bp_ready_next", 32'(out_ready), 32'd1);
        send_beat(8'h7F, 1'b1);
        collect("bp_next");

        send_beat(8'h00, 1'b1);
        collect("single_zero");
        send_beat(8'h80, 1'b1);
        collect("single_negzero");

        for (int i = 0; i < 300; i++) send_beat(8'h00, i == 299);
        collect("cnt_sat");

        for (int s = 0; s < 4; s++) begin
            int len;
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                send_beat(8'($urandom_range(0, 255)), i == len - 1);
            end
            collect("rand");
        end

        // Asynchronous reset between edges discards the partial sum.
        send_beat(8'h10, 1'b0);
        send_beat(8'h10, 1'b0);
        #2 rst_n = 1'b0;
        m_acc = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sum", 32'(out_sum), 32'd0);
        check("mid_rst_count", 32'(out_count), 32'd0);
        check("mid_rst_ovf", 32'(out_overflow), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_ready", 32'(out_ready), 32'd1);
        send_beat(8'h01, 1'b1);
        check("post_rst_literal", 32'(out_sum), 32'h001);
        collect("post_rst");

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
